// File: rtl/axil_code_regs_pkg.sv
// Shared register map, response codes and select type for the code-memory
// register bank that feeds the BPF instruction write sequencer.
package axil_code_regs_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Byte offsets of the mapped word slots
  localparam int CONTROL_OFFSET   = 'h00;
  localparam int STATUS_OFFSET    = 'h04;
  localparam int INST_LOW_OFFSET  = 'h08;
  localparam int INST_HIGH_OFFSET = 'h0C;
  localparam int ID_OFFSET        = 'h10;

  localparam logic [DATA_WIDTH-1:0] ID_VALUE = 32'hB9F0_0001;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CONTROL,
    SEL_STATUS,
    SEL_INST_LOW,
    SEL_INST_HIGH,
    SEL_ID
  } reg_sel_e;

  function automatic logic sel_is_writable(input reg_sel_e sel);
    return (sel == SEL_CONTROL) || (sel == SEL_INST_LOW) || (sel == SEL_INST_HIGH);
  endfunction

  function automatic logic sel_is_readable(input reg_sel_e sel);
    return sel != SEL_NONE;
  endfunction

endpackage

// File: rtl/axil_wr_capture.sv
// AXI4-Lite write front end: latches AW and W independently, raises a one-cycle
// commit once both are held, and owns the B response (one write outstanding).
module axil_wr_capture
  import axil_code_regs_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic                  wr_err,
  output logic                  wr_commit,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [STRB_WIDTH-1:0] wr_strb
);

  logic                  run_reg;
  logic                  aw_held_reg;
  logic                  w_held_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [STRB_WIDTH-1:0] strb_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;
  logic                  aw_fire;
  logic                  w_fire;

  // run_reg keeps both ready outputs low while reset is asserted
  assign s_axi_awready = run_reg && !aw_held_reg && !bvalid_reg;
  assign s_axi_wready  = run_reg && !w_held_reg && !bvalid_reg;
  assign aw_fire       = s_axi_awvalid && s_axi_awready;
  assign w_fire        = s_axi_wvalid && s_axi_wready;
  assign wr_commit     = aw_held_reg && w_held_reg && !bvalid_reg;

  assign wr_addr      = addr_reg;
  assign wr_data      = data_reg;
  assign wr_strb      = strb_reg;
  assign s_axi_bvalid = bvalid_reg;
  assign s_axi_bresp  = bresp_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg     <= 1'b0;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      strb_reg    <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      run_reg <= 1'b1;
      if (aw_fire) begin
        aw_held_reg <= 1'b1;
        addr_reg    <= s_axi_awaddr;
      end
      if (w_fire) begin
        w_held_reg <= 1'b1;
        data_reg   <= s_axi_wdata;
        strb_reg   <= s_axi_wstrb;
      end
      if (wr_commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_reg && s_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_code_regs.sv
// AXI4-Lite register bank for the code-memory write sequencer: instruction halves
// with one-cycle strobes, a level start bit, and write-pointer readback.
module axil_code_regs
  import axil_code_regs_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 6,
  parameter int CODE_ADDR_WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [DATA_WIDTH-1:0]      s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]      s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [DATA_WIDTH-1:0]      s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [DATA_WIDTH-1:0]      inst_low_value,
  output logic                       inst_low_strobe,
  output logic [DATA_WIDTH-1:0]      inst_high_value,
  output logic                       inst_high_strobe,
  output logic                       control_start,
  input  logic [CODE_ADDR_WIDTH-1:0] code_mem_wr_addr
);

  // Byte-lane bits are masked off, so unaligned addresses hit the containing word
  function automatic reg_sel_e decode_addr(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] word;
    word = addr & ~AXI_ADDR_WIDTH'(3);
    if (word == AXI_ADDR_WIDTH'(CONTROL_OFFSET))   return SEL_CONTROL;
    if (word == AXI_ADDR_WIDTH'(STATUS_OFFSET))    return SEL_STATUS;
    if (word == AXI_ADDR_WIDTH'(INST_LOW_OFFSET))  return SEL_INST_LOW;
    if (word == AXI_ADDR_WIDTH'(INST_HIGH_OFFSET)) return SEL_INST_HIGH;
    if (word == AXI_ADDR_WIDTH'(ID_OFFSET))        return SEL_ID;
    return SEL_NONE;
  endfunction

  logic                      wr_commit;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [STRB_WIDTH-1:0]     wr_strb;
  reg_sel_e                  wr_sel;
  logic                      wr_err;
  logic                      wr_low_en;
  logic                      wr_high_en;
  logic                      wr_ctrl_en;

  logic [DATA_WIDTH-1:0] inst_low_reg;
  logic [DATA_WIDTH-1:0] inst_low_next;
  logic [DATA_WIDTH-1:0] inst_high_reg;
  logic [DATA_WIDTH-1:0] inst_high_next;
  logic                  control_start_reg;
  logic                  control_start_next;
  logic                  inst_low_strobe_reg;
  logic                  inst_high_strobe_reg;

  assign wr_sel     = decode_addr(wr_addr);
  assign wr_err     = !sel_is_writable(wr_sel);
  assign wr_low_en  = wr_commit && (wr_sel == SEL_INST_LOW);
  assign wr_high_en = wr_commit && (wr_sel == SEL_INST_HIGH);
  assign wr_ctrl_en = wr_commit && (wr_sel == SEL_CONTROL);

  axil_wr_capture #(
    .ADDR_WIDTH(AXI_ADDR_WIDTH)
  ) u_wr_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .wr_err       (wr_err),
    .wr_commit    (wr_commit),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb)
  );

  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
    assign inst_low_next[gi*8 +: 8]  = (wr_low_en && wr_strb[gi]) ?
                                       wr_data[gi*8 +: 8] : inst_low_reg[gi*8 +: 8];
    assign inst_high_next[gi*8 +: 8] = (wr_high_en && wr_strb[gi]) ?
                                       wr_data[gi*8 +: 8] : inst_high_reg[gi*8 +: 8];
  end

  assign control_start_next = (wr_ctrl_en && wr_strb[0]) ? wr_data[0] : control_start_reg;

  // Strobes follow the register select, not the byte enables: a zero-wstrb write still pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_low_reg         <= '0;
      inst_high_reg        <= '0;
      control_start_reg    <= 1'b0;
      inst_low_strobe_reg  <= 1'b0;
      inst_high_strobe_reg <= 1'b0;
    end else begin
      inst_low_reg         <= inst_low_next;
      inst_high_reg        <= inst_high_next;
      control_start_reg    <= control_start_next;
      inst_low_strobe_reg  <= wr_low_en;
      inst_high_strobe_reg <= wr_high_en;
    end
  end

  assign inst_low_value   = inst_low_reg;
  assign inst_high_value  = inst_high_reg;
  assign inst_low_strobe  = inst_low_strobe_reg;
  assign inst_high_strobe = inst_high_strobe_reg;
  assign control_start    = control_start_reg;

  reg_sel_e              rd_sel;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rd_data_next;
  logic [1:0]            rd_resp_next;
  logic                  rd_run_reg;
  logic                  rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;
  logic                  ar_fire;

  assign rd_sel = decode_addr(s_axi_araddr);

  always_comb begin
    status_word                        = '0;
    status_word[CODE_ADDR_WIDTH-1:0]   = code_mem_wr_addr;
    status_word[DATA_WIDTH-1]          = control_start_reg;
  end

  // Sources are the current registers, so a read alongside a commit sees pre-write data
  always_comb begin
    rd_data_next = '0;
    rd_resp_next = sel_is_readable(rd_sel) ? RESP_OKAY : RESP_SLVERR;
    case (rd_sel)
      SEL_CONTROL:   rd_data_next = {{(DATA_WIDTH-1){1'b0}}, control_start_reg};
      SEL_STATUS:    rd_data_next = status_word;
      SEL_INST_LOW:  rd_data_next = inst_low_reg;
      SEL_INST_HIGH: rd_data_next = inst_high_reg;
      SEL_ID:        rd_data_next = ID_VALUE;
      default:       rd_data_next = '0;
    endcase
  end

  assign s_axi_arready = rd_run_reg && !rvalid_reg;
  assign ar_fire       = s_axi_arvalid && s_axi_arready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_run_reg <= 1'b0;
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else begin
      rd_run_reg <= 1'b1;
      if (ar_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_data_next;
        rresp_reg  <= rd_resp_next;
      end else if (rvalid_reg && s_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  assign s_axi_rvalid = rvalid_reg;
  assign s_axi_rdata  = rdata_reg;
  assign s_axi_rresp  = rresp_reg;

endmodule

// File: doc/axil_code_regs.md
Name: axil_code_regs

Overview:
- AXI4-Lite slave register bank that sits directly upstream of the code-memory write sequencer.
- Host software writes 64-bit BPF instructions as two 32-bit halves, plus a control word.
- Block produces per-register value/one-cycle-strobe pairs and a level control_start bit, the exact interface the sequencer consumes.
- Also gives host readback of the sequencer's current code write address.

Parameters:
- AXI_ADDR_WIDTH, 6, byte address width of the slave window (16 word slots).
- CODE_ADDR_WIDTH, 9, width of the code_mem_wr_addr readback input.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write address.
- s_axi_awvalid  in  1 / s_axi_awready  out  1.
- s_axi_wdata  in  32 / s_axi_wstrb  in  4 / s_axi_wvalid  in  1 / s_axi_wready  out  1.
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1.
- s_axi_araddr  in  AXI_ADDR_WIDTH / s_axi_arvalid  in  1 / s_axi_arready  out  1.
- s_axi_rdata  out  32 / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1.
- inst_low_value  out  32  held INST_LOW register.
- inst_low_strobe  out  1  one-cycle pulse on INST_LOW write.
- inst_high_value  out  32  held INST_HIGH register.
- inst_high_strobe  out  1  one-cycle pulse on INST_HIGH write.
- control_start  out  1  CONTROL[0], level.
- code_mem_wr_addr  in  CODE_ADDR_WIDTH  sequencer write pointer, readback only.

Behaviour:
- Register map (word index = addr[AXI_ADDR_WIDTH-1:2]; addr[1:0] ignored):
  - 0x00 CONTROL: RW; bit0 = start; other bits read 0.
  - 0x04 STATUS: RO; [CODE_ADDR_WIDTH-1:0] = code_mem_wr_addr; bit31 = control_start.
  - 0x08 INST_LOW: RW.
  - 0x0C INST_HIGH: RW.
  - 0x10 ID: RO constant 0xB9F0_0001.
  - All other slots are unmapped.
- Reset (rst_n low, async):
  - All registers 0; all ready/valid outputs 0.
  - Strobes 0; control_start 0; bresp/rresp 0.
  - Any in-flight transaction is abandoned.
- Write channel:
  - AW and W are latched independently, in either order or the same cycle.
  - awready is high while no address is held and bvalid is low; wready likewise for data.
  - Commit cycle T is the first cycle with both address and data held and bvalid low.
  - At T+1: register updated per wstrb byte lanes; matching strobe high for exactly one cycle; bvalid high.
  - bvalid holds until bready; AW/W are not accepted again until the B handshake completes. One write outstanding.
- Strobe rules:
  - Strobe fires on any write to a mapped RW register, even with wstrb = 0 (value unchanged).
  - Only one register is written per transaction, so inst_low_strobe and inst_high_strobe are never high together.
  - Values stay constant between strobes.
- Error responses:
  - Write to RO or unmapped slot: no state change, no strobe, bresp = 2'b10 (SLVERR).
  - Otherwise bresp = 2'b00.
- Read channel:
  - arready is high when rvalid is low.
  - On AR handshake at T: rvalid, rdata and rresp are registered at T+1 and held until rready.
  - Unmapped read: rdata 0, rresp SLVERR.
  - STATUS samples code_mem_wr_addr at T.
- Read/write independence:
  - Read and write channels run concurrently.
  - A read accepted in the same cycle as a write commit returns the pre-write value.
- control_start:
  - Changes only at T+1 of a CONTROL write.
  - Host must clear it before loading instructions; the block does not auto-clear it.

Decomposition:
- Shared package axil_code_regs_pkg holds:
  - Register offsets (CONTROL, STATUS, INST_LOW, INST_HIGH, ID).
  - ID constant.
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Data width 32.
- One natural sub-module: axil_wr_capture, the AW/W independent latch and commit/B-response logic.
- Register decode and the read path stay in the top.

Test Plan:
- Reset, then read ID -> rdata 0xB9F0_0001, rresp 00; all strobes and control_start 0 throughout.
- Write INST_LOW = 0x1234_5678 with AW two cycles before W -> one-cycle inst_low_strobe at T+1, inst_low_value 0x1234_5678, bresp 00, inst_high_strobe never high.
- Write INST_HIGH = 0xFFFF_FFFF with wstrb = 4'b0101 over prior 0 -> inst_high_value 0x00FF_00FF, strobe pulses once.
- Write 0x1 to CONTROL, read STATUS with code_mem_wr_addr = 9'd5 -> control_start 1, rdata 0x8000_0005.
- Write to 0x04 and to 0x20 -> bresp 10 both, no strobe, registers unchanged; read 0x20 -> rdata 0, rresp 10.
- Hold bready low 5 cycles after a write, then assert rst_n low mid-response -> bvalid drops immediately, registers 0, next write accepted normally.
